// File: rtl/jenkins_pkg.sv
// jenkins_pkg: shared widths and feeder FSM encoding for the jenkins hash interface
package jenkins_pkg;
  localparam int HASH_W = 32;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, SEND, TERM, WAIT, DONE} state_t;
endpackage

// File: rtl/jenkins_feeder.sv
// jenkins_feeder: streams a whole key byte-serially into the jenkins core and returns its hash
// Optional hash compare (exp_hash/res_match) enabled by JENKINS_FEEDER_CHECK_EN
module jenkins_feeder
  import jenkins_pkg::*;
#(
  parameter int MAX_LEN = 12,
  parameter int LEN_W   = 8
) (
  input  logic                      CLOCK,
  input  logic                      RESET_N,
  input  logic                      key_valid,
  output logic                      key_ready,
  input  logic [MAX_LEN*BYTE_W-1:0] key,
  input  logic [LEN_W-1:0]          key_len,
`ifdef JENKINS_FEEDER_CHECK_EN
  input  logic [HASH_W-1:0]         exp_hash,
  output logic                      res_match,
`endif
  output logic                      sample,
  output logic [BYTE_W-1:0]         value,
  input  logic [HASH_W-1:0]         hash,
  input  logic                      complete,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [HASH_W-1:0]         res_hash
);
  localparam int KW = MAX_LEN * BYTE_W;
  state_t state, nxt;
  logic [KW-1:0] sr, aligned;
  logic [LEN_W-1:0] cnt, len_sat;
  logic seen, acc;
`ifdef JENKINS_FEEDER_CHECK_EN
  logic [HASH_W-1:0] exp_q;
`endif
  assign len_sat = (key_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : key_len;
  // left-align the key so the first byte to send is always the top byte
  assign aligned = key << (BYTE_W * (MAX_LEN - int'(len_sat)));
  assign acc = key_valid && key_ready;
  assign res_valid = state == DONE;
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = acc ? ((len_sat == '0) ? TERM : SEND) : IDLE;
      SEND: nxt = (cnt == LEN_W'(1)) ? TERM : SEND;
      TERM: nxt = WAIT;
      WAIT: nxt = (seen && complete) ? DONE : WAIT;
      DONE: nxt = res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK or negedge RESET_N)
    if (!RESET_N) begin
      sr        <= '0;
      cnt       <= '0;
      sample    <= 1'b0;
      value     <= '0;
      seen      <= 1'b0;
      key_ready <= 1'b0;
      res_hash  <= '0;
`ifdef JENKINS_FEEDER_CHECK_EN
      exp_q     <= '0;
      res_match <= 1'b0;
`endif
    end else begin
      seen      <= state == WAIT;
      key_ready <= nxt == IDLE;
      if (acc) begin
        sr     <= aligned << BYTE_W;
        cnt    <= len_sat;
        sample <= len_sat != '0;
        value  <= aligned[KW-1 -: BYTE_W];
`ifdef JENKINS_FEEDER_CHECK_EN
        exp_q  <= exp_hash;
`endif
      end else if (state == SEND) begin
        sr     <= sr << BYTE_W;
        cnt    <= cnt - LEN_W'(1);
        sample <= cnt != LEN_W'(1);
        value  <= (cnt != LEN_W'(1)) ? sr[KW-1 -: BYTE_W] : '0;
      end else begin
        sample <= 1'b0;
        value  <= '0;
      end
      if (state == WAIT && nxt == DONE) begin
        res_hash  <= hash;
`ifdef JENKINS_FEEDER_CHECK_EN
        res_match <= hash == exp_q;
`endif
      end
    end
endmodule

// File: tb/tb_jenkins_feeder.sv
// tb_jenkins_feeder: directed vectors for jenkins_feeder against a behavioural one-at-a-time core
module tb_jenkins_feeder;
  localparam int ML = 12;
  localparam int LW = 8;
  localparam int KW = ML * 8;
  logic clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0, res_ready = 1'b0;
  logic complete, sample, key_ready, res_valid;
  logic [KW-1:0] key = '0;
  logic [LW-1:0] key_len = '0;
  logic [7:0] value;
  logic [31:0] hash, res_hash, h;
  logic pend;
`ifdef JENKINS_FEEDER_CHECK_EN
  logic [31:0] exp_hash = '0;
  logic res_match;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  jenkins_feeder #(.MAX_LEN(ML), .LEN_W(LW)) dut (
    .CLOCK(clk), .RESET_N(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .key_len(key_len),
`ifdef JENKINS_FEEDER_CHECK_EN
    .exp_hash(exp_hash), .res_match(res_match),
`endif
    .sample(sample), .value(value), .hash(hash), .complete(complete),
    .res_valid(res_valid), .res_ready(res_ready), .res_hash(res_hash)
  );
  function automatic logic [31:0] mix(logic [31:0] a, logic [7:0] b);
    logic [31:0] x;
    x = a + {24'h0, b};
    x = x + (x << 10);
    return x ^ (x >> 6);
  endfunction
  function automatic logic [31:0] fin(logic [31:0] a);
    logic [31:0] x;
    x = a + (a << 3);
    x = x ^ (x >> 11);
    return x + (x << 15);
  endfunction
  // core: accumulates sampled bytes, finalises on the first non-sample cycle, holds complete high
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h <= '0; pend <= 1'b0; complete <= 1'b0; hash <= '0;
    end else if (key_valid && key_ready) begin
      h <= '0; pend <= 1'b1; complete <= 1'b0;
    end else if (pend && sample) begin
      h <= mix(h, value);
    end else if (pend) begin
      hash <= fin(h); complete <= 1'b1; pend <= 1'b0; h <= '0;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_key(input string nm, input logic [KW-1:0] k, input logic [LW-1:0] l,
                         input logic [31:0] eh, input bit chk_hash);
    int lim, n, c;
    lim = (int'(l) > ML) ? ML : int'(l);
    n = 0;
    c = 1;
    @(negedge clk);
    check({nm, " ready"}, 32'(key_ready), 32'd1);
    key = k; key_len = l; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    while (!res_valid && c < 60) begin
      if (sample) begin
        if (n < lim) check($sformatf("%s byte%0d", nm, n), 32'(value), 32'(k[(lim-1-n)*8 +: 8]));
        n++;
      end
      if (c == lim + 1) check({nm, " term"}, {23'h0, sample, value}, 32'h0);
      @(negedge clk);
      c++;
    end
    check({nm, " count"}, 32'(n), 32'(lim));
    check({nm, " latency"}, 32'(c), 32'(lim + 4));
    if (chk_hash) check({nm, " hash"}, res_hash, eh);
  endtask
  task automatic consume(input string nm);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({nm, " drop valid"}, 32'(res_valid), 32'd0);
    check({nm, " ready again"}, 32'(key_ready), 32'd1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst key_ready", 32'(key_ready), 32'd0);
    check("rst sample", 32'(sample), 32'd0);
    check("rst value", 32'(value), 32'd0);
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst res_hash", res_hash, 32'd0);
    rst_n = 1'b1;
    run_key("a", 96'h61, 8'd1, 32'hca2e9442, 1'b1);
    consume("a");
    run_key("abc", 96'h616263, 8'd3, 32'hed131f5b, 1'b1);
    consume("abc");
    run_key("len0", 96'h0, 8'd0, 32'h0, 1'b1);
    consume("len0");
    run_key("len20", 96'h0c0b0a090807060504030201, 8'd20, 32'h0, 1'b0);
    consume("len20");
    run_key("hold", 96'h61, 8'd1, 32'hca2e9442, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold valid%0d", i), 32'(res_valid), 32'd1);
      check($sformatf("hold hash%0d", i), res_hash, 32'hca2e9442);
      check($sformatf("hold ready%0d", i), 32'(key_ready), 32'd0);
    end
    consume("hold");
    @(negedge clk);
    key = 96'h6162636465; key_len = 8'd5; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("mid byte0", 32'(value), 32'h61);
    @(negedge clk);
    check("mid byte1", 32'(value), 32'h62);
    rst_n = 1'b0;
    #1;
    check("mid sample", 32'(sample), 32'd0);
    check("mid value", 32'(value), 32'd0);
    check("mid res_valid", 32'(res_valid), 32'd0);
    check("mid key_ready", 32'(key_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_key("after rst", 96'h61, 8'd1, 32'hca2e9442, 1'b1);
    consume("after rst");
`ifdef JENKINS_FEEDER_CHECK_EN
    exp_hash = 32'hca2e9442;
    run_key("match", 96'h61, 8'd1, 32'hca2e9442, 1'b1);
    check("match res_match", 32'(res_match), 32'd1);
    consume("match");
    exp_hash = 32'h0;
    run_key("nomatch", 96'h61, 8'd1, 32'hca2e9442, 1'b1);
    check("nomatch res_match", 32'(res_match), 32'd0);
    consume("nomatch");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
